// File: rtl/tmds_period_sched.sv
// Per-pixel TMDS period scheduler: delays pixel/sync data by LAT stages and inserts
// the HDMI video preamble and leading guard band. Optional DVI bypass: TMDS_SCHED_DVI_EN.
module tmds_period_sched #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int MIN_CTRL     = 12
) (
  input  logic       clk,
  input  logic       rst,
`ifdef TMDS_SCHED_DVI_EN
  input  logic       dvi_mode,
`endif
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       de_in,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [3:0] ctl,
  output logic       guard,
  output logic [1:0] period,
  output logic       err_short_ctrl,
  output logic       err_collide
);

  localparam int LAT   = PREAMBLE_LEN + GUARD_LEN + 1;
  localparam int DEPTH = LAT - 1;

  typedef enum logic [1:0] {
    CTRL     = 2'd0,
    PREAMBLE = 2'd1,
    GUARD    = 2'd2,
    VIDEO    = 2'd3
  } state_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  // The output register is the last delay stage, so only LAT-1 stages live here.
  pix_t       pipe [DEPTH];
  pix_t       pix_in;
  pix_t       tail;
  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [5:0] ctrl_cnt, ctrl_cnt_nxt;
  logic       rise;
  logic       dvi;
  logic       set_short;
  logic       set_collide;

`ifdef TMDS_SCHED_DVI_EN
  assign dvi = dvi_mode;
`else
  assign dvi = 1'b0;
`endif

  assign pix_in = '{hs: hsync_in, vs: vsync_in, de: de_in,
                    r: red_in, g: green_in, b: blue_in};
  assign tail   = pipe[DEPTH-1];
  assign rise   = de_in & ~pipe[0].de;
  assign period = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= pix_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  // tail.de is the value the stage-LAT de takes at this edge, keeping VIDEO aligned with it.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    set_short   = 1'b0;
    set_collide = 1'b0;
    unique case (state)
      CTRL: begin
        if (rise && !dvi) begin
          state_nxt = PREAMBLE;
          cnt_nxt   = 4'(PREAMBLE_LEN - 1);
        end else if (tail.de) begin
          state_nxt   = VIDEO;
          set_collide = !dvi;
        end
      end
      PREAMBLE: begin
        if (dvi) begin
          state_nxt = tail.de ? VIDEO : CTRL;
        end else if (cnt == 4'd0) begin
          state_nxt = GUARD;
          cnt_nxt   = 4'(GUARD_LEN - 1);
          set_short = (ctrl_cnt_nxt < 6'(MIN_CTRL));
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      GUARD: begin
        if (dvi) begin
          state_nxt = tail.de ? VIDEO : CTRL;
        end else if (cnt == 4'd0) begin
          state_nxt = VIDEO;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      VIDEO: begin
        if (!tail.de) state_nxt = CTRL;
      end
      default: state_nxt = CTRL;
    endcase
    if (rise && state != CTRL && !dvi) set_collide = 1'b1;
  end

  // ctrl_cnt_nxt includes the current cycle, so at GUARD entry it equals the full
  // control-period length (control cycles plus preamble).
  always_comb begin
    ctrl_cnt_nxt = ctrl_cnt;
    if (state == VIDEO && !tail.de)
      ctrl_cnt_nxt = 6'd0;
    else if ((state == CTRL || state == PREAMBLE) && ctrl_cnt != 6'h3f)
      ctrl_cnt_nxt = ctrl_cnt + 6'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= CTRL;
      cnt            <= 4'd0;
      ctrl_cnt       <= 6'd0;
      hsync          <= 1'b0;
      vsync          <= 1'b0;
      de             <= 1'b0;
      red            <= 8'd0;
      green          <= 8'd0;
      blue           <= 8'd0;
      ctl            <= 4'd0;
      guard          <= 1'b0;
      err_short_ctrl <= 1'b0;
      err_collide    <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      ctrl_cnt       <= ctrl_cnt_nxt;
      hsync          <= tail.hs;
      vsync          <= tail.vs;
      de             <= (state_nxt == VIDEO);
      red            <= (state_nxt == VIDEO) ? tail.r : 8'd0;
      green          <= (state_nxt == VIDEO) ? tail.g : 8'd0;
      blue           <= (state_nxt == VIDEO) ? tail.b : 8'd0;
      ctl            <= {3'b000, state_nxt == PREAMBLE};
      guard          <= (state_nxt == GUARD);
      err_short_ctrl <= err_short_ctrl | set_short;
      err_collide    <= err_collide | set_collide;
    end
  end

endmodule

// File: doc/tmds_period_sched.md
Name: tmds_period_sched

Overview:
- Per-pixel period scheduler between the video timing source and the three TMDS channel encoders.
- Delays pixel and sync data by a fixed pipeline, and inserts an HDMI video preamble and leading guard band ahead of every active-video run.
- Tells the encoders which period to emit each cycle.
- Flags control periods too short to be legal and data-enable edges that arrive too close together to schedule.

Parameters:
PREAMBLE_LEN, 8, preamble length in pixel clocks (1..15)
GUARD_LEN, 2, leading guard band length in pixel clocks (1..3)
MIN_CTRL, 12, minimum control-period length in pixel clocks, preamble included (1..63)

Ports:
clk  in  1  pixel clock; single clock domain
rst  in  1  asynchronous reset, active-low
hsync_in  in  1  timing hsync
vsync_in  in  1  timing vsync
de_in  in  1  timing data enable
red_in / green_in / blue_in  in  8 each  pixel data
hsync / vsync / de  out  1 each  delayed syncs and data enable to the encoders
red / green / blue  out  8 each  delayed pixel data
ctl  out  4  CTL3..CTL0 for the green/red encoder c0/c1 inputs
guard  out  1  encoders emit guard-band code
period  out  2  current period: 0 CTRL, 1 PREAMBLE, 2 GUARD, 3 VIDEO
err_short_ctrl  out  1  sticky error flag
err_collide  out  1  sticky error flag

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0.
  - Delay line cleared. State is CTRL. ctrl_cnt is 0.
  - Both error flags cleared.
  - Error flags clear only on reset.
- Delay line:
  - LAT = PREAMBLE_LEN + GUARD_LEN + 1 register stages (default 11).
  - Carries hsync, vsync, de and RGB.
  - Input sampled at edge N is on hsync/vsync/de/rgb after edge N+LAT-1.
  - All outputs are registered.
- Rise detect: at edge N, rise = de_in & ~stage1_de.
- FSM, registered, transitions at the clock edge:
  - CTRL:
    - On rise, go to PREAMBLE and load the counter with PREAMBLE_LEN-1.
    - Else, if delayed de (stage LAT) = 1, go to VIDEO and set err_collide.
  - PREAMBLE:
    - Counter decrements each edge.
    - At 0, go to GUARD and load the counter with GUARD_LEN-1.
  - GUARD:
    - At 0, go to VIDEO.
    - On entry to GUARD, if ctrl_cnt < MIN_CTRL, set err_short_ctrl.
  - VIDEO:
    - Stays while delayed de = 1.
    - Goes to CTRL on the edge where the stage-LAT de is 0.
- Any rise sampled while the state is not CTRL is ignored for scheduling and sets err_collide; the data still passes through the delay line.
- ctrl_cnt:
  - Saturating 6-bit counter.
  - Cleared on VIDEO→CTRL.
  - Increments every cycle in CTRL or PREAMBLE.
- Output decode, registered with the state:
  - CTRL: ctl=0000, guard=0, de=0.
  - PREAMBLE: ctl=0001, guard=0, de=0.
  - GUARD: ctl=0000, guard=1, de=0.
  - VIDEO: ctl=0000, guard=0, de=1.
  - hsync/vsync are always the delayed values.
  - RGB is forced to 0 unless the state is VIDEO.
- Timing: with rise at edge N and a clean gap, PREAMBLE follows edges N..N+PREAMBLE_LEN-1, GUARD the next GUARD_LEN edges, and VIDEO starts after edge N+LAT-1, aligned with delayed de=1.
- Minimum legal gap:
  - Input de-low gap G ≥ LAT is needed for a preamble to be scheduled.
  - Output control period = (G-LAT+1) + PREAMBLE_LEN.
- Reset mid-operation: outputs return to reset values immediately; the flushed pipeline is not replayed.

Optional Feature:
- Macro: TMDS_SCHED_DVI_EN.
- Defined:
  - Adds input port dvi_mode (1 bit).
  - While dvi_mode=1, the FSM is held in CTRL/VIDEO only: de mirrors delayed de, no PREAMBLE/GUARD, ctl=0000, guard=0.
  - err_short_ctrl and err_collide never set while dvi_mode=1.
  - Pipeline latency is unchanged.
- Undefined: port absent; behaviour is always HDMI as above.

Test Plan:
- Reset: hold rst=0 with random inputs → all outputs 0, period=0. Release → outputs 0 until the delay line fills.
- Clean line: de_in low 100 cycles, then high 20 cycles with blue_in=8'hA5 from edge N →
  - period=1, ctl=0001 after edges N..N+7.
  - period=2, guard=1 after N+8..N+9.
  - de=1, blue=A5 after N+10..N+29, then period=0.
  - No error flags.
- Short control period: gap G=12 between de runs → preamble issued, err_short_ctrl=1. Repeat with G=20 after reset → err_short_ctrl=0.
- Collision: gap G=5 → no PREAMBLE/GUARD for the second run, err_collide=1, second-run pixels still appear with de=1 after LAT-1.
- Async reset mid-preamble: drop rst at edge N+3 → all outputs 0 immediately, state CTRL. A clean rise 100 cycles later is scheduled normally.
- With TMDS_SCHED_DVI_EN, dvi_mode=1, same stimulus as clean line → period never 1/2, de=1 after N+10, flags stay 0.
